// File: rtl/vga_pixel_arbiter.sv
// vga_pixel_arbiter: buffers painter pixel writes in a small FIFO and forwards
// them to the VGA framebuffer adapter one per cycle, with a full-screen
// background clear sweep that suspends FIFO pops while it runs.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | pop one FIFO entry per cycle when non-empty
// S_CLEAR | sweep (0,0)..(X_MAX,Y_MAX) with BG_COLOUR; FIFO keeps filling
module vga_pixel_arbiter #(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [2:0] BG_COLOUR  = 3'b000,
  parameter int         X_MAX      = 159,
  parameter int         Y_MAX      = 119
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear_req,
  input  logic [7:0] in_x,
  input  logic [6:0] in_y,
  input  logic [2:0] in_colour,
  input  logic       in_plot,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       clear_done,
  output logic       overflow
);

  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   L_DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   L_CONE  = (AW+1)'(1);
  localparam logic [AW-1:0] L_PONE  = AW'(1);
  localparam logic [7:0]    L_XMAX  = 8'(X_MAX);
  localparam logic [6:0]    L_YMAX  = 7'(Y_MAX);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW:0]   r_count;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [17:0]   r_mem [FIFO_DEPTH];
  logic [7:0]    r_cx;
  logic [6:0]    r_cy;
  logic          r_sweep_end;
  logic [7:0]    r_vga_x;
  logic [6:0]    r_vga_y;
  logic [2:0]    r_vga_colour;
  logic          r_vga_plot;
  logic          r_clear_done;
  logic          r_overflow;

  logic w_pop;
  logic w_sweep_go;
  logic w_sweep_last;
  logic w_clear_start;
  logic w_in_range;
  logic w_push_req;
  logic w_push;
  logic w_drop;
  logic w_full;
  logic w_empty;

  assign w_in_range = (in_x <= L_XMAX) && (in_y <= L_YMAX);
  assign w_push_req = in_plot && w_in_range;
  assign w_full     = (r_count == L_DEPTH);
  assign w_empty    = (r_count == '0);
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state and per-cycle actions; a clear request beats a pending pop.
  always_comb begin
    w_state_nxt   = r_state;
    w_pop         = 1'b0;
    w_sweep_go    = 1'b0;
    w_sweep_last  = 1'b0;
    w_clear_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (clear_req) begin
          w_state_nxt   = S_CLEAR;
          w_clear_start = 1'b1;
        end else if (!w_empty) begin
          w_pop = 1'b1;
        end
      end
      S_CLEAR: begin
        w_sweep_go = 1'b1;
        if (r_cx == L_XMAX && r_cy == L_YMAX) begin
          w_sweep_last = 1'b1;
          w_state_nxt  = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + L_PONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + L_PONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + L_CONE;
        2'b01:   r_count <= r_count - L_CONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are meaningless while the occupancy is zero.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {in_x, in_y, in_colour};
  end

  // Clear sweep counters, x fastest, restarted on every entry to S_CLEAR.
  always_ff @(posedge clk) begin
    if (!resetn || w_clear_start) begin
      r_cx <= '0;
      r_cy <= '0;
    end else if (w_sweep_go) begin
      if (r_cx == L_XMAX) begin
        r_cx <= '0;
        r_cy <= (r_cy == L_YMAX) ? 7'd0 : r_cy + 7'd1;
      end else begin
        r_cx <= r_cx + 8'd1;
      end
    end
  end

  // Registered adapter outputs; coordinates hold when nothing is issued.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= '0;
      r_vga_plot   <= 1'b0;
    end else begin
      r_vga_plot <= w_pop || w_sweep_go;
      if (w_sweep_go) begin
        r_vga_x      <= r_cx;
        r_vga_y      <= r_cy;
        r_vga_colour <= BG_COLOUR;
      end else if (w_pop) begin
        {r_vga_x, r_vga_y, r_vga_colour} <= r_mem[r_rd_ptr];
      end
    end
  end

  // clear_done trails the last sweep pixel by one cycle; overflow is sticky.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sweep_end  <= 1'b0;
      r_clear_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_sweep_end  <= w_sweep_last;
      r_clear_done <= r_sweep_end;
      r_overflow   <= r_overflow || w_drop;
    end
  end

  assign vga_x      = r_vga_x;
  assign vga_y      = r_vga_y;
  assign vga_colour = r_vga_colour;
  assign vga_plot   = r_vga_plot;
  assign clear_done = r_clear_done;
  assign overflow   = r_overflow;
  assign busy       = (r_state == S_CLEAR) || !w_empty;

endmodule

// File: tb/tb_vga_pixel_arbiter.sv
// Testbench for vga_pixel_arbiter: table vectors plus hand-written sequences,
// with a scoreboard queue filled by the stimulus and drained by a monitor.
module tb_vga_pixel_arbiter;

  localparam int NPIX = 160 * 120;

  logic       clk;
  logic       resetn;
  logic       clear_req;
  logic [7:0] in_x;
  logic [6:0] in_y;
  logic [2:0] in_colour;
  logic       in_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       clear_done;
  logic       overflow;

  vga_pixel_arbiter dut (
    .clk(clk), .resetn(resetn), .clear_req(clear_req),
    .in_x(in_x), .in_y(in_y), .in_colour(in_colour), .in_plot(in_plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .clear_done(clear_done), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       last;
  } exp_t;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       plot;
    logic       emit;
  } vec_t;

  exp_t q[$];
  vec_t vecs[10];
  int   checks = 0;
  int   errors = 0;
  int   plot_cnt = 0;
  logic mon_en = 1'b0;
  logic exp_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every issued pixel must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && resetn) begin
      chk("clear_done", clear_done, exp_done);
      exp_done = 1'b0;
      if (vga_plot) begin
        plot_cnt++;
        if (q.size() == 0) begin
          chk("unexpected_plot", vga_plot, 0);
        end else begin
          e = q.pop_front();
          chk("vga_x", vga_x, e.x);
          chk("vga_y", vga_y, e.y);
          chk("vga_colour", vga_colour, e.c);
          if (e.last) exp_done = 1'b1;
        end
      end
    end
  end

  task automatic idle_inputs();
    in_plot   = 1'b0;
    clear_req = 1'b0;
  endtask

  task automatic push_clear_expect();
    exp_t e;
    for (int yy = 0; yy < 120; yy++)
      for (int xx = 0; xx < 160; xx++) begin
        e.x = 8'(xx); e.y = 7'(yy); e.c = 3'b000;
        e.last = (xx == 159 && yy == 119);
        q.push_back(e);
      end
  endtask

  task automatic drive_px(input logic [7:0] x, input logic [6:0] y,
                          input logic [2:0] c, input logic emit);
    exp_t e;
    in_x = x; in_y = y; in_colour = c; in_plot = 1'b1;
    if (emit) begin
      e.x = x; e.y = y; e.c = c; e.last = 1'b0;
      q.push_back(e);
    end
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && q.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    chk("drain_queue_empty", q.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_vga_x"}, vga_x, 0);
    chk({tag, "_vga_y"}, vga_y, 0);
    chk({tag, "_vga_colour"}, vga_colour, 0);
    chk({tag, "_vga_plot"}, vga_plot, 0);
    chk({tag, "_clear_done"}, clear_done, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic single_pixel();
    @(negedge clk);
    drive_px(8'd4, 7'd36, 3'd7, 1'b1);
    @(negedge clk);
    chk("single_plot_e1", vga_plot, 0);
    in_plot = 1'b0;
    @(negedge clk);
    chk("single_plot_e2", vga_plot, 1);
    chk("single_x", vga_x, 4);
    chk("single_y", vga_y, 36);
    chk("single_c", vga_colour, 7);
    chk("single_overflow", overflow, 0);
    @(negedge clk);
    chk("single_plot_after", vga_plot, 0);
    drain(5);
  endtask

  task automatic clear_backlog(input int npush);
    @(negedge clk);
    clear_req = 1'b1;
    push_clear_expect();
    @(negedge clk);
    clear_req = 1'b0;
    chk("clr_plot_e1", vga_plot, 0);
    for (int i = 0; i < npush; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 1) begin
        chk("clr_first_plot", vga_plot, 1);
        chk("clr_first_x", vga_x, 0);
        chk("clr_first_y", vga_y, 0);
        chk("clr_busy", busy, 1);
      end
      drive_px(8'(100 + i), 7'd68, 3'd7, i < 8);
    end
    @(negedge clk);
    in_plot = 1'b0;
    for (int k = 0; k < NPIX + 100; k++) begin
      if (clear_done) break;
      @(negedge clk);
    end
    chk("clr_done_seen", clear_done, 1);
    chk("clr_pop_with_done", vga_plot, 1);
    chk("clr_pop_x_with_done", vga_x, 100);
    drain(30);
    chk("clr_overflow", overflow, (npush > 8) ? 1 : 0);
    chk("clr_busy_end", busy, 0);
  endtask

  initial begin
    int start;
    vecs[0] = '{8'd0,   7'd0,   3'd1, 1'b1, 1'b1};
    vecs[1] = '{8'd159, 7'd119, 3'd2, 1'b1, 1'b1};
    vecs[2] = '{8'd160, 7'd0,   3'd7, 1'b1, 1'b0};
    vecs[3] = '{8'd0,   7'd120, 3'd7, 1'b1, 1'b0};
    vecs[4] = '{8'd50,  7'd60,  3'd5, 1'b0, 1'b0};
    vecs[5] = '{8'd255, 7'd127, 3'd3, 1'b1, 1'b0};
    vecs[6] = '{8'd159, 7'd0,   3'd4, 1'b1, 1'b1};
    vecs[7] = '{8'd0,   7'd119, 3'd6, 1'b1, 1'b1};
    vecs[8] = '{8'd80,  7'd64,  3'd3, 1'b1, 1'b1};
    vecs[9] = '{8'd161, 7'd119, 3'd1, 1'b1, 1'b0};

    // Reset with random inputs
    resetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      clear_req = 1'($urandom); in_plot = 1'($urandom);
      in_x = 8'($urandom); in_y = 7'($urandom); in_colour = 3'($urandom);
      @(negedge clk);
      check_outputs_zero("reset");
    end
    idle_inputs();
    resetn = 1'b1;
    mon_en = 1'b1;

    single_pixel();

    // Streaming 16 pixels back to back
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      if (i >= 2) chk("stream_plot", vga_plot, 1);
      drive_px(8'(i), 7'd4, 3'b111, 1'b1);
    end
    @(negedge clk);
    in_plot = 1'b0;
    chk("stream_plot_tail1", vga_plot, 1);
    chk("stream_busy_tail1", busy, 1);
    @(negedge clk);
    chk("stream_plot_tail2", vga_plot, 1);
    chk("stream_busy_fall", busy, 0);
    @(negedge clk);
    chk("stream_plot_end", vga_plot, 0);
    chk("stream_overflow", overflow, 0);
    drain(5);

    // Table vectors incl. range filter
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive_px(vecs[i].x, vecs[i].y, vecs[i].c, vecs[i].emit);
      in_plot = vecs[i].plot;
    end
    @(negedge clk);
    in_plot = 1'b0;
    drain(20);
    chk("table_overflow", overflow, 0);

    clear_backlog(8);
    clear_backlog(9);

    // Reset mid-clear
    @(negedge clk);
    clear_req = 1'b1;
    push_clear_expect();
    @(negedge clk);
    clear_req = 1'b0;
    start = plot_cnt;
    for (int k = 0; k < 200 && (plot_cnt - start) < 100; k++) @(negedge clk);
    chk("midclr_reached_100", ((plot_cnt - start) >= 100) ? 1 : 0, 1);
    resetn = 1'b0;
    mon_en = 1'b0;
    q.delete();
    exp_done = 1'b0;
    @(negedge clk);
    check_outputs_zero("midclr_rst1");
    @(negedge clk);
    check_outputs_zero("midclr_rst2");
    resetn = 1'b1;
    mon_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("midclr_no_plot", vga_plot, 0);
    end
    single_pixel();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
